fb_fill_sched: RTL and testbench

- Scheduler that owns the single port of the 640x480 4-bit colour-index framebuffer.
- Gives the port to the display scan read whenever `de` is high.
- Uses blanking cycles to execute rectangle-fill commands from a drawing requester, so the framebuffer can be updated at runtime instead of only from an initial image.
- Sits between the display timing generator and the framebuffer RAM. RAM read data feeds the palette lookup.

---
 rtl/fb_fill_sched.sv | 166 ++++++++++++++++
 tb/tb_fb_fill_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_fill_sched.sv
// fb_fill_sched: arbiter for the single port of the 640x480 4-bit
// colour-index framebuffer.
//   - Display scan reads (de=1) always own the port.
//   - Blanking cycles (de=0) are used to run rectangle-fill commands,
//     one pixel write per granted cycle, in raster order (x inner).
// Ports:
//   clk_pix, rst (sync, active-low)      clock / reset
//   de, sx, sy                           scan request from the timing generator
//   cmd_valid/cmd_ready, cmd_x0..y1,     fill command handshake; rectangle is
//   cmd_color                            inclusive and clamped to the screen
//   mem_en, mem_we, mem_addr, mem_wdata  registered RAM port (1-cycle latency)
//   busy                                 fill in progress
//   done                                 one-cycle pulse, aligned with the
//                                        last write showing on mem_*
module fb_fill_sched #(
    parameter int CORDW       = 10,
    parameter int DISP_WIDTH  = 640,
    parameter int DISP_HEIGHT = 480,
    parameter int ADDRW       = 19
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             de,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CORDW-1:0] cmd_x0,
    input  logic [CORDW-1:0] cmd_y0,
    input  logic [CORDW-1:0] cmd_x1,
    input  logic [CORDW-1:0] cmd_y1,
    input  logic [3:0]       cmd_color,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [3:0]       mem_wdata,
    output logic             busy,
    output logic             done
);

    localparam logic [CORDW-1:0] X_MAX = CORDW'(DISP_WIDTH - 1);
    localparam logic [CORDW-1:0] Y_MAX = CORDW'(DISP_HEIGHT - 1);
    localparam logic [ADDRW-1:0] LINE  = ADDRW'(DISP_WIDTH);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t           state_q, state_d;
    logic [CORDW-1:0] x0_q, x0_d;
    logic [CORDW-1:0] x1_q, x1_d;
    logic [CORDW-1:0] y1_q, y1_d;
    logic [CORDW-1:0] cx_q, cx_d;
    logic [CORDW-1:0] cy_q, cy_d;
    logic [3:0]       color_q, color_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]       mem_wdata_q, mem_wdata_d;

    logic [CORDW-1:0] x1c, y1c;
    logic             cmd_empty;
    logic             accept;
    logic             wr_grant;
    logic [ADDRW-1:0] scan_addr, cur_addr;

    always_comb begin
        cmd_ready = rst && (state_q == IDLE);
        busy      = (state_q == FILL);
        done      = (state_q == DONE);
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

    always_comb begin
        x1c       = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        y1c       = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        // Empty once clamped: start off-screen or start past end.
        cmd_empty = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX) ||
                    (cmd_x0 > x1c)   || (cmd_y0 > y1c);
        accept    = cmd_valid && cmd_ready;
        wr_grant  = (state_q == FILL) && !de;
        scan_addr = ADDRW'(sy)   * LINE + ADDRW'(sx);
        cur_addr  = ADDRW'(cy_q) * LINE + ADDRW'(cx_q);

        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        color_d     = color_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    x0_d    = cmd_x0;
                    x1_d    = x1c;
                    y1_d    = y1c;
                    cx_d    = cmd_x0;
                    cy_d    = cmd_y0;
                    color_d = cmd_color;
                    state_d = cmd_empty ? DONE : FILL;
                end
            end
            FILL: begin
                // Cursor only moves on cycles the write actually gets the port.
                if (wr_grant) begin
                    if (cx_q != x1_q) begin
                        cx_d = cx_q + CORDW'(1);
                    end else if (cy_q != y1_q) begin
                        cx_d = x0_q;
                        cy_d = cy_q + CORDW'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (de) begin
            mem_en_d   = 1'b1;
            mem_addr_d = scan_addr;
        end else if (wr_grant) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = cur_addr;
            mem_wdata_d = color_q;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            color_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            color_q     <= color_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_fb_fill_sched.sv
// Testbench for fb_fill_sched: a pixel-write queue reference model is
// checked on every cycle, plus a read-path vector table and directed
// corner-case sequences, followed by random traffic.
module tb_fb_fill_sched;

    logic       clk_pix = 1'b0;
    logic       rst = 1'b0;
    logic       de = 1'b0;
    logic [9:0] sx = '0, sy = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [3:0] cmd_color = '0;
    logic       mem_en, mem_we;
    logic [18:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       busy, done;

    fb_fill_sched #(.CORDW(10), .DISP_WIDTH(640), .DISP_HEIGHT(480), .ADDRW(19)) dut (
        .clk_pix(clk_pix), .rst(rst), .de(de), .sx(sx), .sy(sy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk_pix = ~clk_pix;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: list of pixel writes still owed by the current command.
    typedef struct { int addr; int color; } wr_t;
    wr_t mq[$];
    logic m_done = 1'b0;
    logic m_en = 1'b0, m_we = 1'b0;
    int   m_addr = 0, m_wd = 0;
    int   m_acc = 0;
    int   wr_log[$];
    int   done_cnt = 0;

    typedef struct {
        logic       de;
        logic [9:0] sx, sy;
        logic       exp_en, exp_we;
        int         exp_addr;
    } rd_vec_t;
    rd_vec_t tbl[6];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void push_rect(input int x0, input int y0, input int x1, input int y1, input int col);
        int x1c, y1c;
        x1c = (x1 > 639) ? 639 : x1;
        y1c = (y1 > 479) ? 479 : y1;
        if (x0 > 639 || y0 > 479 || x0 > x1c || y0 > y1c) return;
        for (int y = y0; y <= y1c; y++)
            for (int x = x0; x <= x1c; x++)
                mq.push_back('{addr: y * 640 + x, color: col});
    endfunction

    // One clock: check cmd_ready, predict, advance, check registered outputs.
    task automatic step();
        logic ready_exp;
        wr_t  w;
        #1;
        ready_exp = rst && (mq.size() == 0) && !m_done;
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, ready_exp});
        if (!rst) begin
            mq.delete();
            m_done = 1'b0; m_en = 1'b0; m_we = 1'b0; m_addr = 0; m_wd = 0;
        end else begin
            m_done = 1'b0;
            if (de) begin
                m_en = 1'b1; m_we = 1'b0; m_addr = int'(sy) * 640 + int'(sx);
            end else if (mq.size() != 0) begin
                w = mq.pop_front();
                m_en = 1'b1; m_we = 1'b1; m_addr = w.addr; m_wd = w.color;
                if (mq.size() == 0) m_done = 1'b1;
            end else begin
                m_en = 1'b0; m_we = 1'b0;
            end
            if (ready_exp && cmd_valid) begin
                m_acc++;
                push_rect(int'(cmd_x0), int'(cmd_y0), int'(cmd_x1), int'(cmd_y1), int'(cmd_color));
                if (mq.size() == 0) m_done = 1'b1;
            end
        end
        @(posedge clk_pix);
        #1;
        chk("mem_en",    {31'b0, mem_en}, {31'b0, m_en});
        chk("mem_we",    {31'b0, mem_we}, {31'b0, m_we});
        chk("mem_addr",  {13'b0, mem_addr}, m_addr);
        chk("mem_wdata", {28'b0, mem_wdata}, m_wd);
        chk("busy",      {31'b0, busy}, {31'b0, (mq.size() != 0)});
        chk("done",      {31'b0, done}, {31'b0, m_done});
        if (mem_en && mem_we) wr_log.push_back(int'(mem_addr));
        if (done) done_cnt++;
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1, input int col);
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
        cmd_color = 4'(col);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_idle(input string nm, input int max_cyc);
        int k = 0;
        while ((mq.size() != 0 || m_done) && k < max_cyc) begin
            step();
            k++;
        end
        if (mq.size() != 0 || m_done) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout after %0d cycles, %0d writes pending", nm, max_cyc, mq.size());
        end
        step();   // settle into IDLE so cmd_ready is 1 again
    endtask

    initial begin
        int d0;

        tbl[0] = '{de: 1'b1, sx: 10'd5,   sy: 10'd2,   exp_en: 1'b1, exp_we: 1'b0, exp_addr: 1285};
        tbl[1] = '{de: 1'b0, sx: 10'd0,   sy: 10'd0,   exp_en: 1'b0, exp_we: 1'b0, exp_addr: 1285};
        tbl[2] = '{de: 1'b1, sx: 10'd639, sy: 10'd479, exp_en: 1'b1, exp_we: 1'b0, exp_addr: 307199};
        tbl[3] = '{de: 1'b1, sx: 10'd0,   sy: 10'd0,   exp_en: 1'b1, exp_we: 1'b0, exp_addr: 0};
        tbl[4] = '{de: 1'b0, sx: 10'd7,   sy: 10'd7,   exp_en: 1'b0, exp_we: 1'b0, exp_addr: 0};
        tbl[5] = '{de: 1'b1, sx: 10'd1,   sy: 10'd1,   exp_en: 1'b1, exp_we: 1'b0, exp_addr: 641};

        // Reset
        rst = 1'b0;
        step();
        step();
        chk("rst_en", {31'b0, mem_en}, 0);
        chk("rst_addr", {13'b0, mem_addr}, 0);
        rst = 1'b1;

        // Read path vectors while idle
        for (int i = 0; i < 6; i++) begin
            de = tbl[i].de; sx = tbl[i].sx; sy = tbl[i].sy;
            step();
            chk("tbl_en",   {31'b0, mem_en}, {31'b0, tbl[i].exp_en});
            chk("tbl_we",   {31'b0, mem_we}, {31'b0, tbl[i].exp_we});
            chk("tbl_addr", {13'b0, mem_addr}, tbl[i].exp_addr);
        end
        de = 1'b0;
        step();

        // Basic fill
        wr_log.delete(); d0 = done_cnt;
        send_cmd(10, 20, 11, 21, 5);
        for (int i = 0; i < 4; i++) step();
        chk("basic_done_on_last", {31'b0, done}, 1);
        chk("basic_nwr", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            chk("basic_a0", wr_log[0], 12810);
            chk("basic_a1", wr_log[1], 12811);
            chk("basic_a2", wr_log[2], 13450);
            chk("basic_a3", wr_log[3], 13451);
        end
        run_until_idle("basic_idle", 10);
        chk("basic_ready", {31'b0, cmd_ready}, 1);
        chk("basic_ndone", done_cnt - d0, 1);

        // Stall with de in the middle of a fill
        wr_log.delete();
        send_cmd(10, 20, 11, 21, 5);
        step(); step();
        de = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sx = 10'(100 + i); sy = 10'd3;
            step();
        end
        de = 1'b0;
        run_until_idle("stall_idle", 20);
        chk("stall_nwr", wr_log.size(), 4);
        if (wr_log.size() == 4) chk("stall_a2", wr_log[2], 13450);

        // Clamp
        wr_log.delete();
        send_cmd(636, 479, 700, 600, 9);
        run_until_idle("clamp_idle", 20);
        chk("clamp_nwr", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            chk("clamp_a0", wr_log[0], 307196);
            chk("clamp_a3", wr_log[3], 307199);
        end

        // Empty command
        wr_log.delete(); d0 = done_cnt;
        send_cmd(20, 5, 10, 5, 3);
        chk("empty_done", {31'b0, done}, 1);
        run_until_idle("empty_idle", 5);
        chk("empty_nwr", wr_log.size(), 0);
        chk("empty_ndone", done_cnt - d0, 1);

        // Backpressure: second command held valid during the first fill
        wr_log.delete(); d0 = m_acc;
        cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_x1 = 10'd2; cmd_y1 = 10'd1; cmd_color = 4'd7;
        cmd_valid = 1'b1;
        step();
        cmd_x0 = 10'd50; cmd_y0 = 10'd60; cmd_x1 = 10'd51; cmd_y1 = 10'd60; cmd_color = 4'd2;
        for (int k = 0; k < 40 && m_acc < d0 + 2; k++) step();
        cmd_valid = 1'b0;
        chk("bp_accepts", m_acc - d0, 2);
        run_until_idle("bp_idle", 20);
        chk("bp_nwr", wr_log.size(), 8);

        // Reset mid-fill
        wr_log.delete(); d0 = done_cnt;
        send_cmd(100, 100, 103, 103, 4);
        step(); step();
        rst = 1'b0;
        step();
        chk("rstmid_busy", {31'b0, busy}, 0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("rstmid_nwr", wr_log.size(), 2);
        chk("rstmid_ndone", done_cnt - d0, 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            int x0, y0, w, h;
            de = ($urandom_range(0, 2) == 0);
            sx = 10'($urandom_range(0, 639));
            sy = 10'($urandom_range(0, 479));
            rst = ($urandom_range(0, 799) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            x0 = $urandom_range(0, 700); y0 = $urandom_range(0, 520);
            w = $urandom_range(0, 6);    h = $urandom_range(0, 4);
            cmd_x0 = 10'(x0); cmd_y0 = 10'(y0);
            cmd_x1 = 10'((w == 0 && x0 > 0) ? x0 - 1 : x0 + w);
            cmd_y1 = 10'((h == 0 && y0 > 0) ? y0 - 1 : y0 + h);
            cmd_color = 4'($urandom_range(0, 15));
            step();
        end
        rst = 1'b1; cmd_valid = 1'b0; de = 1'b0;
        run_until_idle("rand_idle", 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
